// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the arbiter, its two requesters (IF, DM) and the unified memory port.
// The arbiter connects through the slave modport; the environment drives through master.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic [DW-1:0]     if_rdata;
    logic              if_ack;

    logic              dm_req;
    logic              dm_we;
    logic [DW/8-1:0]   dm_be;
    logic [AW-1:0]     dm_addr;
    logic [DW-1:0]     dm_wdata;
    logic [DW-1:0]     dm_rdata;
    logic              dm_ack;

    logic              mem_en;
    logic              mem_we;
    logic [DW/8-1:0]   mem_be;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              mem_ready;

    logic              err;

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output mem_rdata, mem_ready,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, err
    );

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  mem_rdata, mem_ready,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IF) and load/store (DM).
// Define ARB_TIMEOUT_EN to abort accesses that see no mem_ready within TIMEOUT BUSY cycles.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int BW = DW / 8;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("TIMEOUT must be at least 1");
    end

    state_t        state_q, state_d;
    logic          owner_dm_q, owner_dm_d;
    logic          last_dm_q, last_dm_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [BW-1:0] be_q, be_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          pick_dm;
    logic          busy;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        owner_dm_d = owner_dm_q;
        last_dm_d  = last_dm_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        addr_d     = addr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        // On a tie the requester that did not win last time gets the port.
        pick_dm = bus.dm_req && (!bus.if_req || !last_dm_q);

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    state_d    = BUSY;
                    owner_dm_d = pick_dm;
                    last_dm_d  = pick_dm;
                    addr_d     = pick_dm ? bus.dm_addr : bus.if_addr;
                    we_d       = pick_dm & bus.dm_we;
                    be_d       = pick_dm ? bus.dm_be : '1;
                    wdata_d    = pick_dm ? bus.dm_wdata : '0;
`ifdef ARB_TIMEOUT_EN
                    cnt_d      = '0;
                    err_d      = 1'b0;
`endif
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    state_d = RESP;
                    if (!owner_dm_q)
                        if_rdata_d = bus.mem_rdata;
                    else if (!we_q)
                        dm_rdata_d = bus.mem_rdata;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (!owner_dm_q)
                        if_rdata_d = '0;
                    else
                        dm_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy          = (state_q == BUSY);
        bus.mem_en    = busy;
        bus.mem_we    = busy & we_q;
        bus.mem_be    = busy ? be_q : '0;
        bus.mem_addr  = busy ? addr_q : '0;
        bus.mem_wdata = busy ? wdata_q : '0;
        bus.if_ack    = (state_q == RESP) && !owner_dm_q;
        bus.dm_ack    = (state_q == RESP) && owner_dm_q;
        bus.if_rdata  = if_rdata_q;
        bus.dm_rdata  = dm_rdata_q;
`ifdef ARB_TIMEOUT_EN
        bus.err       = (state_q == RESP) && err_q;
`else
        bus.err       = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_dm_q <= 1'b0;
            last_dm_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_dm_q <= owner_dm_d;
            last_dm_q  <= last_dm_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    // Latched access fields are only visible while BUSY, so they need no reset.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        we_q    <= we_d;
        be_q    <= be_d;
        wdata_q <= wdata_d;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-timeline reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  int n_checks = 0;
  int n_errors = 0;

  req_t        q_if[$];
  req_t        q_dm[$];
  int          q_k[$];
  logic [31:0] q_mem[$];
  int          rate_if = 0;
  int          rate_dm = 0;

  req_t        cur_if, cur_dm;
  bit          pend_if, pend_dm;
  bit          act, acc_dm, tmo, last_dm, cur_busy, cur_resp;
  int          t, k, blen;
  req_t        acc;
  logic [31:0] acc_data, exp_if_rd, exp_dm_rd;
  bit          ack_log[$];
  int          err_seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic req_t mk_req(input logic [31:0] a, input bit we, input logic [3:0] be,
                                  input logic [31:0] wd);
    req_t r;
    r.addr = a; r.we = we; r.be = be; r.wdata = wd;
    return r;
  endfunction

  function automatic req_t rand_req();
    return mk_req($urandom, 1'($urandom_range(1)), 4'($urandom), $urandom);
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".mem_en"}, bus.mem_en, 0);
    chk({tag, ".mem_we"}, bus.mem_we, 0);
    chk({tag, ".mem_be"}, bus.mem_be, 0);
    chk({tag, ".mem_addr"}, bus.mem_addr, 0);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, ".if_ack"}, bus.if_ack, 0);
    chk({tag, ".dm_ack"}, bus.dm_ack, 0);
    chk({tag, ".if_rdata"}, bus.if_rdata, 0);
    chk({tag, ".dm_rdata"}, bus.dm_rdata, 0);
    chk({tag, ".err"}, bus.err, 0);
  endtask

  // Drive requesters and memory for the current cycle; arbitrate in an idle cycle.
  task automatic drive();
    if (!pend_if) begin
      if (q_if.size() > 0) begin cur_if = q_if.pop_front(); pend_if = 1; end
      else if (int'($urandom_range(99)) < rate_if) begin cur_if = rand_req(); pend_if = 1; end
    end
    if (!pend_dm) begin
      if (q_dm.size() > 0) begin cur_dm = q_dm.pop_front(); pend_dm = 1; end
      else if (int'($urandom_range(99)) < rate_dm) begin cur_dm = rand_req(); pend_dm = 1; end
    end
    bus.if_req   = pend_if;
    bus.if_addr  = pend_if ? cur_if.addr : $urandom;
    bus.dm_req   = pend_dm;
    bus.dm_addr  = pend_dm ? cur_dm.addr : $urandom;
    bus.dm_we    = pend_dm ? cur_dm.we : 1'($urandom_range(1));
    bus.dm_be    = pend_dm ? cur_dm.be : 4'($urandom);
    bus.dm_wdata = pend_dm ? cur_dm.wdata : $urandom;

    bus.mem_rdata = $urandom;
    if (cur_busy) begin
      bus.mem_ready = !tmo && (t == k + 1);
      if (bus.mem_ready) bus.mem_rdata = acc_data;
    end else begin
      bus.mem_ready = 1'($urandom_range(1));
    end

    if (cur_resp) begin
      if (acc_dm) pend_dm = 0; else pend_if = 0;
      act = 0;
    end else if (!act && (pend_if || pend_dm)) begin
      acc_dm = pend_dm && (!pend_if || !last_dm);
      acc = acc_dm ? cur_dm : cur_if;
      if (!acc_dm) begin acc.we = 0; acc.be = 4'hF; end
      last_dm = acc_dm;
      k = (q_k.size() > 0) ? q_k.pop_front() : int'($urandom_range(4));
      acc_data = (q_mem.size() > 0) ? q_mem.pop_front() : $urandom;
      tmo  = TMO_EN && (k >= TIMEOUT);
      blen = tmo ? TIMEOUT : k + 1;
      act  = 1;
      t    = 0;
    end
  endtask

  task automatic sample();
    if (act) t++;
    cur_busy = act && (t >= 1) && (t <= blen);
    cur_resp = act && (t == blen + 1);
    if (cur_resp) begin
      if (tmo) begin
        if (acc_dm) exp_dm_rd = 0; else exp_if_rd = 0;
      end else if (!acc_dm) exp_if_rd = acc_data;
      else if (!acc.we) exp_dm_rd = acc_data;
    end
    chk("mem_en", bus.mem_en, cur_busy);
    if (cur_busy) begin
      chk("mem_addr", bus.mem_addr, acc.addr);
      chk("mem_we", bus.mem_we, acc.we);
      chk("mem_be", bus.mem_be, acc.be);
      if (acc.we) chk("mem_wdata", bus.mem_wdata, acc.wdata);
    end
    chk("if_ack", bus.if_ack, cur_resp && !acc_dm);
    chk("dm_ack", bus.dm_ack, cur_resp && acc_dm);
    chk("err", bus.err, cur_resp && tmo);
    chk("if_rdata", bus.if_rdata, exp_if_rd);
    chk("dm_rdata", bus.dm_rdata, exp_dm_rd);
    if (bus.if_ack) ack_log.push_back(1'b0);
    if (bus.dm_ack) ack_log.push_back(1'b1);
    if (bus.err) err_seen++;
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic do_reset(input bit hold_if);
    rst = 1'b0;
    act = 0; cur_busy = 0; cur_resp = 0; last_dm = 0;
    pend_if = 0; pend_dm = 0; exp_if_rd = 0; exp_dm_rd = 0;
    bus.if_req = hold_if; bus.if_addr = 32'h40;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_ready = 1'b1; bus.mem_rdata = $urandom;
    #1;
    chk_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst_hold");
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(1'b1);

    // Single fetch straight out of reset
    ack_log.delete();
    q_if.push_back(mk_req(32'h0000_0040, 1'b0, 4'h0, 32'h0));
    q_k.push_back(0);
    q_mem.push_back(32'h2008_0005);
    step();
    chk("rst_rel_en", bus.mem_en, 1);
    chk("rst_rel_addr", bus.mem_addr, 32'h40);
    repeat (4) step();
    chk("fetch_rdata", bus.if_rdata, 32'h2008_0005);
    chk("fetch_acks", ack_log.size(), 1);
    chk("fetch_owner", ack_log[0], 0);

    // Store then load of the same word
    q_dm.push_back(mk_req(32'h100, 1'b1, 4'b0011, 32'hDEAD_BEEF));
    q_dm.push_back(mk_req(32'h100, 1'b0, 4'hF, 32'h0));
    q_k.push_back(0); q_k.push_back(1);
    q_mem.push_back(32'h1234_5678); q_mem.push_back(32'h0000_BEEF);
    step();
    chk("st_we", bus.mem_we, 1);
    chk("st_be", bus.mem_be, 4'b0011);
    chk("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    step();
    chk("st_keep", bus.dm_rdata, 0);
    repeat (6) step();
    chk("ld_rdata", bus.dm_rdata, 32'h0000_BEEF);

    // Contention from reset: both requesters held for four accesses
    do_reset(1'b0);
    ack_log.delete();
    repeat (2) begin q_if.push_back(rand_req()); q_dm.push_back(rand_req()); end
    repeat (30) step();
    chk("rr_count", ack_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("rr_order", ack_log[i], (i % 2 == 0) ? 1 : 0);

    // Slow memory with a DM request arriving mid-access
    ack_log.delete();
    q_if.push_back(rand_req());
    q_k.push_back(5); q_k.push_back(0);
    repeat (2) step();
    q_dm.push_back(rand_req());
    repeat (12) step();
    chk("slow_count", ack_log.size(), 2);
    chk("slow_first", ack_log[0], 0);
    chk("slow_second", ack_log[1], 1);

    // Memory that never answers, then one answering on the last allowed BUSY cycle
    ack_log.delete();
    err_seen = 0;
    q_dm.push_back(mk_req(32'h200, 1'b0, 4'hF, 32'h0)); q_k.push_back(200);
    q_dm.push_back(mk_req(32'h204, 1'b0, 4'hF, 32'h0)); q_k.push_back(TIMEOUT - 1);
    q_mem.push_back(32'hCAFE_0001); q_mem.push_back(32'hCAFE_0002);
    repeat (100) step();
`ifndef ARB_TIMEOUT_EN
    chk("hang_en", bus.mem_en, 1);
    chk("hang_err", bus.err, 0);
`endif
    for (int i = 0; i < 200 && ack_log.size() < 2; i++) step();
    chk("tmo_acks", ack_log.size(), 2);
    chk("tmo_err_cnt", err_seen, TMO_EN ? 1 : 0);
    chk("tmo_last_rd", bus.dm_rdata, 32'hCAFE_0002);

    // Random traffic with an asynchronous reset dropped in mid-run
    rate_if = 35;
    rate_dm = 35;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (i == 1500) do_reset(1'b0);
    end
    rate_if = 0;
    rate_dm = 0;
    repeat (40) step();
    chk("drain_idle", bus.mem_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
